// File: rtl/pll_reconfig_ctrl.sv
// PLL reset/lock sequencer with runtime divider reconfiguration.
// Handles lock acquisition, timeout retries, a sticky FAIL state and a lock-loss counter.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// RST_ASSERT | pll_reset high for RST_CYCLES cycles
// WAIT_LOCK  | pll_reset low, waiting up to LOCK_TIMEOUT cycles for lock_s
// STABLE     | lock_s seen, qualifying LOCK_STABLE consecutive high samples
// RUN        | locked; a lock drop counts a loss and restarts the sequence
// FAIL       | retries exhausted, pll_reset held until a new config arrives
module pll_reconfig_ctrl #(
   parameter int unsigned RST_CYCLES   = 16,
   parameter int unsigned LOCK_TIMEOUT = 65535,
   parameter int unsigned LOCK_STABLE  = 1024,
   parameter int unsigned MAX_RETRY    = 3,
   parameter logic [5:0]  DEF_IDSEL    = 6'd61,
   parameter logic [5:0]  DEF_FBDSEL   = 6'd36,
   parameter logic [5:0]  DEF_ODSEL    = 6'd61
) (
   input  logic       clkin,
   input  logic       rst_n,
   input  logic       cfg_valid,
   output logic       cfg_ready,
   input  logic [5:0] cfg_idsel,
   input  logic [5:0] cfg_fbdsel,
   input  logic [5:0] cfg_odsel,
   input  logic       pll_lock,
   output logic       pll_reset,
   output logic [5:0] pll_idsel,
   output logic [5:0] pll_fbdsel,
   output logic [5:0] pll_odsel,
   output logic       locked,
   output logic       err,
   output logic [7:0] loss_cnt
);

   localparam logic [15:0] RST_TC     = 16'(RST_CYCLES - 1);
   localparam logic [15:0] TIMEOUT_TC = 16'(LOCK_TIMEOUT - 1);
   // The WAIT_LOCK sample that moves us into STABLE is the first good sample,
   // so STABLE itself only needs LOCK_STABLE-1 more.
   localparam logic [15:0] STABLE_TC  = 16'((LOCK_STABLE > 1) ? (LOCK_STABLE - 2) : 0);
   localparam logic [7:0]  RETRY_MAX  = 8'(MAX_RETRY);

   typedef enum logic [2:0] {
      RST_ASSERT = 3'd0,
      WAIT_LOCK  = 3'd1,
      STABLE     = 3'd2,
      RUN        = 3'd3,
      FAIL       = 3'd4
   } state_t;

   state_t      state;
   logic [15:0] timer;
   logic [7:0]  retry;
   logic        lock_m;
   logic        lock_s;
   logic        xfer;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   assign xfer = cfg_valid && cfg_ready;

   always_ff @(posedge clkin or negedge rst_n) begin
      if (!rst_n) begin
         lock_m <= 1'b0;
         lock_s <= 1'b0;
      end else begin
         lock_m <= pll_lock;
         lock_s <= lock_m;
      end
   end

   always_ff @(posedge clkin or negedge rst_n) begin
      if (!rst_n) begin
         state      <= RST_ASSERT;
         timer      <= '0;
         retry      <= '0;
         pll_reset  <= 1'b1;
         pll_idsel  <= DEF_IDSEL;
         pll_fbdsel <= DEF_FBDSEL;
         pll_odsel  <= DEF_ODSEL;
         cfg_ready  <= 1'b0;
         locked     <= 1'b0;
         err        <= 1'b0;
         loss_cnt   <= '0;
      end else begin
         // A loss in RUN is counted even when a transfer wins the same edge.
         if (state == RUN && !lock_s && loss_cnt != 8'hFF)
            loss_cnt <= loss_cnt + 8'd1;

         if (xfer) begin
            pll_idsel  <= cfg_idsel;
            pll_fbdsel <= cfg_fbdsel;
            pll_odsel  <= cfg_odsel;
            state      <= RST_ASSERT;
            timer      <= '0;
            retry      <= '0;
            pll_reset  <= 1'b1;
            cfg_ready  <= 1'b0;
            locked     <= 1'b0;
            err        <= 1'b0;
         end else begin
            case (state)
               RST_ASSERT: begin
                  if (timer == RST_TC) begin
                     state     <= WAIT_LOCK;
                     timer     <= '0;
                     pll_reset <= 1'b0;
                  end else begin
                     timer <= sat_inc(timer);
                  end
               end
               WAIT_LOCK: begin
                  if (lock_s) begin
                     state <= STABLE;
                     timer <= '0;
                  end else if (timer == TIMEOUT_TC) begin
                     timer     <= '0;
                     pll_reset <= 1'b1;
                     if (retry < RETRY_MAX) begin
                        retry <= retry + 8'd1;
                        state <= RST_ASSERT;
                     end else begin
                        state     <= FAIL;
                        cfg_ready <= 1'b1;
                        err       <= 1'b1;
                     end
                  end else begin
                     timer <= sat_inc(timer);
                  end
               end
               STABLE: begin
                  if (!lock_s) begin
                     state <= WAIT_LOCK;
                     timer <= '0;
                  end else if (timer == STABLE_TC) begin
                     state     <= RUN;
                     timer     <= '0;
                     retry     <= '0;
                     locked    <= 1'b1;
                     cfg_ready <= 1'b1;
                  end else begin
                     timer <= sat_inc(timer);
                  end
               end
               RUN: begin
                  if (!lock_s) begin
                     state     <= RST_ASSERT;
                     timer     <= '0;
                     retry     <= '0;
                     pll_reset <= 1'b1;
                     locked    <= 1'b0;
                     cfg_ready <= 1'b0;
                  end
               end
               FAIL: begin
                  pll_reset <= 1'b1;
               end
               default: begin
                  state     <= RST_ASSERT;
                  timer     <= '0;
                  retry     <= '0;
                  pll_reset <= 1'b1;
                  cfg_ready <= 1'b0;
                  locked    <= 1'b0;
                  err       <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
